// File: rtl/imm_issue_seq_if.sv
// Fetch, control-unit and ID/EX signal bundle of the issue sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface imm_issue_seq_if #(
    parameter int INSTR_W = 16
) ();
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic               if_ready;
    logic               id_stall;
    logic [5:0]         cu_opcode;
    logic               cu_flush;
    logic [3:0]         cu_mem;
    logic [5:0]         cu_ex;
    logic [2:0]         cu_wb;
    logic               idex_valid;
    logic [3:0]         idex_mem;
    logic [5:0]         idex_ex;
    logic [2:0]         idex_wb;
    logic [INSTR_W-1:0] idex_imm;

    modport slave (
        input  if_valid, if_instr, id_stall, cu_flush, cu_mem, cu_ex, cu_wb,
        output if_ready, cu_opcode, idex_valid, idex_mem, idex_ex, idex_wb, idex_imm
    );

    modport master (
        output if_valid, if_instr, id_stall, cu_flush, cu_mem, cu_ex, cu_wb,
        input  if_ready, cu_opcode, idex_valid, idex_mem, idex_ex, idex_wb, idex_imm
    );
endinterface

// File: rtl/imm_issue_seq.sv
// Decode-to-execute issue sequencer: registers the control-unit bundle into ID/EX and
// pairs two-word instructions (control unit raises flush) with their immediate word.
module imm_issue_seq #(
    parameter int INSTR_W = 16,
    parameter int OPC_LSB = 10
) (
    input  logic            clk,
    input  logic            rst,
    imm_issue_seq_if.slave  bus
);
    localparam logic [5:0] OPC_NOP = 6'b000101;

    typedef enum logic {RUN, WAIT_IMM} state_t;

    typedef struct packed {
        logic [3:0] mem;
        logic [5:0] ex;
        logic [2:0] wb;
    } ctl_t;

    localparam ctl_t CTL_NOP = '{mem: 4'b0000, ex: 6'b000010, wb: 3'b011};

    state_t             r_state, w_state_nxt;
    ctl_t               r_pend, w_pend_nxt;
    ctl_t               r_ctl, w_ctl_nxt;
    ctl_t               w_cu;
    logic               r_valid, w_valid_nxt;
    logic [INSTR_W-1:0] r_imm, w_imm_nxt;
    logic               w_accept;

    assign w_accept      = bus.if_valid && !bus.id_stall;
    assign w_cu          = '{mem: bus.cu_mem, ex: bus.cu_ex, wb: bus.cu_wb};
    assign bus.if_ready  = !bus.id_stall;
    // Immediate data must never reach the decoder as an opcode.
    assign bus.cu_opcode = (r_state == WAIT_IMM) ? OPC_NOP
                                                 : bus.if_instr[OPC_LSB+5:OPC_LSB];

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_ctl_nxt   = r_ctl;
        w_valid_nxt = r_valid;
        w_imm_nxt   = r_imm;
        if (!bus.id_stall) begin
            w_ctl_nxt   = CTL_NOP;
            w_valid_nxt = 1'b0;
            w_imm_nxt   = '0;
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        if (bus.cu_flush) begin
                            w_pend_nxt  = w_cu;
                            w_state_nxt = WAIT_IMM;
                        end else begin
                            w_ctl_nxt   = w_cu;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                WAIT_IMM: begin
                    if (w_accept) begin
                        w_ctl_nxt   = r_pend;
                        w_imm_nxt   = bus.if_instr;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pend  <= '0;
            r_ctl   <= CTL_NOP;
            r_valid <= 1'b0;
            r_imm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ctl   <= w_ctl_nxt;
            r_valid <= w_valid_nxt;
            r_imm   <= w_imm_nxt;
        end
    end

    assign bus.idex_valid = r_valid;
    assign bus.idex_mem   = r_ctl.mem;
    assign bus.idex_ex    = r_ctl.ex;
    assign bus.idex_wb    = r_ctl.wb;
    assign bus.idex_imm   = r_imm;
endmodule

// File: tb/tb_imm_issue_seq.sv
// Bench for imm_issue_seq: table-driven control unit, instruction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_imm_issue_seq;
    localparam int INSTR_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imm_issue_seq_if #(.INSTR_W(INSTR_W)) bus ();

    imm_issue_seq #(.INSTR_W(INSTR_W), .OPC_LSB(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Control unit stand-in: one fixed table entry per opcode.
    logic       t_fl  [64];
    logic [3:0] t_mem [64];
    logic [5:0] t_ex  [64];
    logic [2:0] t_wb  [64];

    always_comb begin
        bus.cu_flush = t_fl[bus.cu_opcode];
        bus.cu_mem   = t_mem[bus.cu_opcode];
        bus.cu_ex    = t_ex[bus.cu_opcode];
        bus.cu_wb    = t_wb[bus.cu_opcode];
    end

    // Reference model: ID/EX contents plus "an immediate is owed" and the owed bundle.
    logic               m_owed;
    logic [12:0]        m_pend;
    logic               m_valid;
    logic [12:0]        m_ctl;
    logic [INSTR_W-1:0] m_imm;

    localparam logic [12:0] BUBBLE = {4'b0000, 6'b000010, 3'b011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [15:0] w, input logic s);
        logic [5:0] op;
        op = w[15:10];
        if (r) begin
            m_owed = 1'b0; m_pend = '0;
            m_valid = 1'b0; m_ctl = BUBBLE; m_imm = '0;
        end else if (s) begin
            // downstream hold: nothing moves
        end else if (!v) begin
            m_valid = 1'b0; m_ctl = BUBBLE; m_imm = '0;
        end else if (m_owed) begin
            m_valid = 1'b1; m_ctl = m_pend; m_imm = w; m_owed = 1'b0;
        end else if (t_fl[op]) begin
            m_pend = {t_mem[op], t_ex[op], t_wb[op]};
            m_owed = 1'b1;
            m_valid = 1'b0; m_ctl = BUBBLE; m_imm = '0;
        end else begin
            m_valid = 1'b1; m_ctl = {t_mem[op], t_ex[op], t_wb[op]}; m_imm = '0;
        end
    endtask

    // One clock: drive, check combinational outputs, clock, check ID/EX.
    task automatic step(input logic r, input logic v, input logic [15:0] w, input logic s);
        rst          = r;
        bus.if_valid = v;
        bus.if_instr = w;
        bus.id_stall = s;
        #1;
        chk("if_ready", {31'b0, bus.if_ready}, {31'b0, !s});
        chk("cu_opcode", {26'b0, bus.cu_opcode}, {26'b0, (m_owed ? 6'b000101 : w[15:10])});
        model_step(r, v, w, s);
        @(posedge clk);
        #1;
        chk("idex_valid", {31'b0, bus.idex_valid}, {31'b0, m_valid});
        chk("idex_ctl", {19'b0, bus.idex_mem, bus.idex_ex, bus.idex_wb}, {19'b0, m_ctl});
        chk("idex_imm", {16'b0, bus.idex_imm}, {16'b0, m_imm});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            t_fl[i]  = ($urandom_range(0, 3) == 0);
            t_mem[i] = 4'($urandom);
            t_ex[i]  = 6'($urandom);
            t_wb[i]  = 3'($urandom);
        end
        t_fl[3] = 1'b0; t_ex[3] = 6'b001010; t_wb[3] = 3'b101; t_mem[3] = 4'b0000;  // ADD
        t_fl[1] = 1'b1; t_mem[1] = 4'b1000;  t_wb[1] = 3'b110;                      // LDM
        t_fl[5] = 1'b1;  // NOP entry raises flush: must be ignored while waiting for an immediate

        m_owed = 1'b0; m_pend = '0; m_valid = 1'b0; m_ctl = BUBBLE; m_imm = '0;
        rst = 1'b1; bus.if_valid = 1'b0; bus.if_instr = '0; bus.id_stall = 1'b0;
        @(posedge clk);
        #1;

        // reset for two clocks, ID/EX bubble, if_ready high
        step(1'b1, 1'b1, 16'h0400, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst_ex", {26'b0, bus.idex_ex}, 32'h02);
        chk("rst_wb", {29'b0, bus.idex_wb}, 32'h3);

        // single-word ADD
        step(1'b0, 1'b1, 16'h0C00, 1'b0);
        chk("add_ex", {26'b0, bus.idex_ex}, 32'h0A);
        chk("add_wb", {29'b0, bus.idex_wb}, 32'h5);

        // LDM then immediate back to back
        step(1'b0, 1'b1, 16'h0400, 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk("ldm_imm", {16'b0, bus.idex_imm}, 32'hBEEF);
        chk("ldm_mem", {28'b0, bus.idex_mem}, 32'h8);

        // LDM, three idle cycles, immediate
        step(1'b0, 1'b1, 16'h0400, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0C00, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("ldm_gap_imm", {16'b0, bus.idex_imm}, 32'h1234);

        // LDM, immediate held by stall for two cycles
        step(1'b0, 1'b1, 16'h0400, 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("stall_valid", {31'b0, bus.idex_valid}, 32'h0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk("stall_imm", {16'b0, bus.idex_imm}, 32'hBEEF);

        // valid instruction frozen under stall
        step(1'b0, 1'b1, 16'h0C00, 1'b0);
        step(1'b0, 1'b1, 16'h0400, 1'b1);
        chk("stall_hold_ex", {26'b0, bus.idex_ex}, 32'h0A);

        // reset while waiting discards the pending LDM
        step(1'b0, 1'b1, 16'h0400, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0C00, 1'b0);
        chk("rst_wait_imm", {16'b0, bus.idex_imm}, 32'h0);
        chk("rst_wait_ex", {26'b0, bus.idex_ex}, 32'h0A);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r, v, s;
            logic [15:0] w;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:10] = 6'($urandom_range(0, 1) ? 1 : 5);
            step(r, v, w, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
